alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the N-bit ripple adder.
- Captures the adder's sum/carry together with operand sign bits and derives the flags: zero, negative, signed overflow.
- Presents the result to the consumer over a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered ready_o, so the combinational adder path is not extended by consumer backpressure.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_skid_buf.sv | 92 +++++++++
 rtl/alu_result_stage.sv | 76 +++++++
 tb/tb_alu_result_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU result stage.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

  // Encoding is {main_v, skid_v}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_t;

  function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with a registered ready_o.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         ready_q;
  logic         main_v;
  logic         accept, transfer;
  logic         load_main, load_skid, main_from_skid;

  assign main_v   = state_q[1];
  assign accept   = valid_i && ready_q;
  assign transfer = main_v && ready_i;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d   = SKID_ONE;
          load_main = 1'b1;
        end
      end
      SKID_ONE: begin
        case ({accept, transfer})
          2'b10: begin
            state_d   = SKID_FULL;
            load_skid = 1'b1;
          end
          2'b11:   load_main = 1'b1;
          2'b01:   state_d   = SKID_EMPTY;
          default: ;
        endcase
      end
      SKID_FULL: begin
        if (transfer) begin
          state_d        = SKID_ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // ready is the registered complement of the next skid occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SKID_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != SKID_FULL);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= data_i;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= data_i;
      end
    end
  end

  assign valid_o = main_v;
  assign ready_o = ready_q;
  assign data_o  = main_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag derivation, skid-buffered handshake
// and a sticky signed-overflow flag.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N = ALU_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [N-1:0] sum_i,
  input  logic         carry_i,
  input  logic         a_msb_i,
  input  logic         b_msb_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] result_o,
  output logic         carry_o,
  output logic         zero_o,
  output logic         neg_o,
  output logic         ovf_o,
  input  logic         clr_i,
  output logic         ovf_sticky_o
);

  localparam int W = N + 4;

  alu_flags_t   in_flags, out_flags;
  logic [N-1:0] out_sum;
  logic [W-1:0] in_payload, out_payload;
  logic         sticky_q;

  // Flags are computed before the buffer so they travel with their sum.
  always_comb begin
    in_flags.carry = carry_i;
    in_flags.zero  = (sum_i == '0);
    in_flags.neg   = sum_i[N-1];
    in_flags.ovf   = calc_ovf(a_msb_i, b_msb_i, sum_i[N-1]);
  end

  assign in_payload           = {sum_i, in_flags};
  assign {out_sum, out_flags} = out_payload;

  alu_skid_buf #(
    .W (W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (in_payload),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (out_payload)
  );

  // Setting on an overflowing transfer takes priority over clr_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= 1'b0;
    end else if (valid_o && ready_i && out_flags.ovf) begin
      sticky_q <= 1'b1;
    end else if (clr_i) begin
      sticky_q <= 1'b0;
    end
  end

  assign result_o     = out_sum;
  assign carry_o      = out_flags.carry;
  assign zero_o       = out_flags.zero;
  assign neg_o        = out_flags.neg;
  assign ovf_o        = out_flags.ovf;
  assign ovf_sticky_o = sticky_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: expected beats are built from the
// real operands when accepted and compared when the DUT hands them over.
module tb_alu_result_stage;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] result;
    logic         carry;
    logic         zero;
    logic         neg;
    logic         ovf;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         valid_i;
  logic         ready_o;
  logic [N-1:0] sum_i;
  logic         carry_i;
  logic         a_msb_i;
  logic         b_msb_i;
  logic         valid_o;
  logic         ready_i;
  logic [N-1:0] result_o;
  logic         carry_o;
  logic         zero_o;
  logic         neg_o;
  logic         ovf_o;
  logic         clr_i;
  logic         ovf_sticky_o;

  int           checks = 0;
  int           passes = 0;
  exp_t         scoreboard[$];
  exp_t         mon_exp;
  exp_t         held_payload;
  logic         held_valid = 1'b0;
  logic         sticky_model = 1'b0;
  logic         set_now;
  logic [N-1:0] cur_a, cur_b;

  alu_result_stage #(.N(N)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .sum_i        (sum_i),
    .carry_i      (carry_i),
    .a_msb_i      (a_msb_i),
    .b_msb_i      (b_msb_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .result_o     (result_o),
    .carry_o      (carry_o),
    .zero_o       (zero_o),
    .neg_o        (neg_o),
    .ovf_o        (ovf_o),
    .clr_i        (clr_i),
    .ovf_sticky_o (ovf_sticky_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    else
      passes++;
  endtask

  // Expected beat from real two's-complement operand values.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t         m;
    logic [N:0]   full;
    int           sa, sb, ss;
    full     = {1'b0, a} + {1'b0, b};
    sa       = a[N-1] ? int'(a) - (1 << N) : int'(a);
    sb       = b[N-1] ? int'(b) - (1 << N) : int'(b);
    ss       = sa + sb;
    m.result = full[N-1:0];
    m.carry  = full[N];
    m.zero   = (full[N-1:0] == '0);
    m.neg    = full[N-1];
    m.ovf    = (ss > (1 << (N - 1)) - 1) || (ss < -(1 << (N - 1)));
    return m;
  endfunction

  task automatic applyStimulus(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic rdy, input logic clr);
    @(posedge clk_i);
    #1;
    valid_i          = v;
    cur_a            = a;
    cur_b            = b;
    {carry_i, sum_i} = {1'b0, a} + {1'b0, b};
    a_msb_i          = a[N-1];
    b_msb_i          = b[N-1];
    ready_i          = rdy;
    clr_i            = clr;
  endtask

  // Inputs change just after posedge, so at negedge they describe the coming edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      set_now = 1'b0;
      if (held_valid && valid_o)
        checkOutput("stall_stable", {result_o, carry_o, zero_o, neg_o, ovf_o}, held_payload);
      if (valid_o && ready_i) begin
        if (scoreboard.size() == 0) begin
          checkOutput("sb_underflow", 1, 0);
        end else begin
          mon_exp = scoreboard.pop_front();
          checkOutput("result", result_o, mon_exp.result);
          checkOutput("carry", carry_o, mon_exp.carry);
          checkOutput("zero", zero_o, mon_exp.zero);
          checkOutput("neg", neg_o, mon_exp.neg);
          checkOutput("ovf", ovf_o, mon_exp.ovf);
          set_now = mon_exp.ovf;
        end
      end
      checkOutput("sticky", ovf_sticky_o, sticky_model);
      sticky_model = set_now ? 1'b1 : (clr_i ? 1'b0 : sticky_model);
      held_valid   = valid_o && !ready_i;
      held_payload = {result_o, carry_o, zero_o, neg_o, ovf_o};
      if (valid_i && ready_o)
        scoreboard.push_back(model(cur_a, cur_b));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b1;
    sum_i   = 4'b1010;
    carry_i = 1'b1;
    a_msb_i = 1'b1;
    b_msb_i = 1'b1;
    ready_i = 1'b1;
    clr_i   = 1'b0;
    cur_a   = '0;
    cur_b   = '0;

    // Reset held while upstream claims valid data.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_ready", ready_o, 0);
    checkOutput("rst_result", result_o, 0);
    checkOutput("rst_carry", carry_o, 0);
    checkOutput("rst_zero", zero_o, 0);
    checkOutput("rst_neg", neg_o, 0);
    checkOutput("rst_ovf", ovf_o, 0);
    checkOutput("rst_sticky", ovf_sticky_o, 0);
    @(posedge clk_i);
    #2;
    valid_i = 1'b0;
    rst_ni  = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("ready_after_reset", ready_o, 1);

    // Positive overflow 0111 + 0001.
    applyStimulus(1, 4'd7, 4'd1, 1, 0);
    applyStimulus(0, 4'd0, 4'd0, 1, 0);
    @(negedge clk_i);
    checkOutput("ovf_latency_valid", valid_o, 1);
    checkOutput("ovf_latency_result", result_o, 4'b1000);
    applyStimulus(0, 4'd0, 4'd0, 1, 0);
    @(negedge clk_i);
    checkOutput("ovf_sticky_set", ovf_sticky_o, 1);
    applyStimulus(0, 4'd0, 4'd0, 1, 1);
    applyStimulus(0, 4'd0, 4'd0, 1, 0);
    @(negedge clk_i);
    checkOutput("sticky_cleared", ovf_sticky_o, 0);

    // Zero with carry, then a mixed-sign negative result.
    applyStimulus(1, 4'b1000, 4'b1000, 1, 0);
    applyStimulus(1, 4'b0111, 4'b1000, 1, 0);
    applyStimulus(0, 4'd0, 4'd0, 1, 1);
    applyStimulus(0, 4'd0, 4'd0, 1, 0);

    // Backpressure: three beats while the consumer stalls.
    applyStimulus(1, 4'd1, 4'd0, 0, 0);
    applyStimulus(1, 4'd2, 4'd0, 0, 0);
    applyStimulus(1, 4'd3, 4'd0, 0, 0);
    @(negedge clk_i);
    checkOutput("bp_ready_low", ready_o, 0);
    checkOutput("bp_head", result_o, 1);
    applyStimulus(1, 4'd3, 4'd0, 0, 0);
    @(negedge clk_i);
    checkOutput("bp_still_full", ready_o, 0);
    applyStimulus(1, 4'd3, 4'd0, 1, 0);
    applyStimulus(1, 4'd3, 4'd0, 1, 0);
    @(negedge clk_i);
    checkOutput("bp_ready_back", ready_o, 1);
    checkOutput("bp_second", result_o, 2);
    applyStimulus(0, 4'd0, 4'd0, 1, 0);
    @(negedge clk_i);
    checkOutput("bp_third", result_o, 3);
    applyStimulus(0, 4'd0, 4'd0, 1, 0);
    @(negedge clk_i);
    checkOutput("bp_drained", valid_o, 0);

    // Streaming: eight back-to-back beats with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 4'(i), 4'd0, 1, 0);
      @(negedge clk_i);
      checkOutput("stream_ready", ready_o, 1);
      if (i > 0) checkOutput("stream_valid", valid_o, 1);
    end
    applyStimulus(0, 4'd0, 4'd0, 1, 0);
    @(negedge clk_i);
    checkOutput("stream_last_valid", valid_o, 1);
    applyStimulus(0, 4'd0, 4'd0, 1, 0);
    @(negedge clk_i);
    checkOutput("stream_end", valid_o, 0);

    // Sticky set and clear in the same cycle: set wins.
    applyStimulus(1, 4'd7, 4'd1, 1, 0);
    applyStimulus(0, 4'd0, 4'd0, 1, 1);
    applyStimulus(0, 4'd0, 4'd0, 1, 1);
    @(negedge clk_i);
    checkOutput("sticky_set_wins", ovf_sticky_o, 1);
    applyStimulus(0, 4'd0, 4'd0, 1, 0);
    @(negedge clk_i);
    checkOutput("sticky_clear_after", ovf_sticky_o, 0);

    // Asynchronous reset while FULL with the sticky flag set.
    applyStimulus(1, 4'd7, 4'd1, 1, 0);
    applyStimulus(0, 4'd0, 4'd0, 1, 0);
    applyStimulus(1, 4'd1, 4'd0, 0, 0);
    applyStimulus(1, 4'd2, 4'd0, 0, 0);
    applyStimulus(0, 4'd0, 4'd0, 0, 0);
    @(negedge clk_i);
    checkOutput("full_before_reset", ready_o, 0);
    checkOutput("sticky_before_reset", ovf_sticky_o, 1);
    #2;
    rst_ni = 1'b0;
    scoreboard.delete();
    sticky_model = 1'b0;
    held_valid   = 1'b0;
    #1;
    checkOutput("async_rst_valid", valid_o, 0);
    checkOutput("async_rst_sticky", ovf_sticky_o, 0);
    checkOutput("async_rst_result", result_o, 0);
    @(posedge clk_i);
    #2;
    ready_i = 1'b1;
    rst_ni  = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("post_rst_ready", ready_o, 1);
    checkOutput("post_rst_no_stale", valid_o, 0);

    // A fresh beat after reset must flow normally.
    applyStimulus(1, 4'd5, 4'd6, 1, 0);
    repeat (3) applyStimulus(0, 4'd0, 4'd0, 1, 0);
    @(negedge clk_i);
    checkOutput("sb_drained", scoreboard.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
